// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between two requesters:
//   requester 0 (core fetch/load/store) and requester 1 (loader/debug).
//   Each transaction holds the memory for MEM_LAT cycles and then returns a
//   one-cycle acknowledge to the owning requester.
//
//   Build option: define MEM_ARB_FIXED_PRIO_EN to give requester 1 fixed
//   priority on contention. Without it, contention is resolved round-robin.
//
// Parameters: AW address width, DW data width, MEM_LAT access cycles (1..15)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rN_req/we/addr/wdata  requester N command (held until rN_ack)
//   rN_ack                requester N completion pulse
//   rdata                 data of the last completed read
//   mem_en/we/addr/wdata  memory command
//   mem_rdata             memory read data
//   busy, owner           transaction in progress, granted requester
//
// state  | meaning
// IDLE   | no access in progress, arbitrate pending requests
// ACCESS | memory access running, wait counter active
// DONE   | acknowledge cycle for the owner
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter starts at MEM_LAT-1 so that reaching zero marks the last access cycle.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       cnt_tc;
  logic       we_q;
  logic       last_owner;
  logic       grant_any;
  logic       grant_sel;

  assign grant_any = r0_req | r1_req;
  assign cnt_tc    = (cnt == 4'd0);

  always_comb begin
    grant_sel = 1'b0;
    if (r0_req && r1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_sel = 1'b1;
`else
      grant_sel = ~last_owner;
`endif
    end else if (r1_req) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  if (cnt_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    r0_ack = 1'b0;
    r1_ack = 1'b0;
    busy   = 1'b0;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        busy   = 1'b1;
      end
      DONE: begin
        busy   = 1'b1;
        r0_ack = ~owner;
        r1_ack = owner;
      end
      default: ;
    endcase
  end

  // Command latch, wait counter and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= 4'd0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        we_q       <= grant_sel ? r1_we    : r0_we;
        mem_addr   <= grant_sel ? r1_addr  : r0_addr;
        mem_wdata  <= grant_sel ? r1_wdata : r0_wdata;
        owner      <= grant_sel;
        last_owner <= grant_sel;
        cnt        <= CNT_INIT;
      end
      if (state == ACCESS) begin
        if (cnt_tc) begin
          if (!we_q) rdata <= mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic          clk;
  logic          reset;
  logic          r0_req, r0_we, r0_ack;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_we, r1_ack;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          gap;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t rq0[$];
  txn_t rq1[$];
  txn_t cur[2];
  bit   pend[2];
  int   gap[2];
  bit   ack_now[2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level reference: one transaction at a time, granted in
  // cycle m_t, occupying the memory in m_t+1..m_t+LAT, acked in m_t+LAT+1.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  bit          m_owner  = 1'b0;
  bit          m_last   = 1'b1;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_rdata  = '0;

  int ack_log[$];
  int ack_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    if (a == 32'h4)  return 32'h55;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic advance(input int r);
    txn_t t;
    int   qsz;
    if (pend[r] && ack_now[r]) begin
      pend[r] = 1'b0;
      gap[r]  = 0;
    end
    if (!pend[r]) begin
      qsz = (r == 0) ? rq0.size() : rq1.size();
      if (qsz > 0) begin
        t = (r == 0) ? rq0[0] : rq1[0];
        if (gap[r] >= t.gap) begin
          if (r == 0) cur[0] = rq0.pop_front();
          else        cur[1] = rq1.pop_front();
          pend[r] = 1'b1;
        end else begin
          gap[r]++;
        end
      end else begin
        gap[r]++;
      end
    end
  endtask

  task automatic drive_ports();
    r0_req = pend[0];
    if (pend[0]) begin
      r0_we = cur[0].we; r0_addr = cur[0].addr; r0_wdata = cur[0].wdata;
    end else begin
      r0_we = 1'($urandom); r0_addr = $urandom; r0_wdata = $urandom;
    end
    r1_req = pend[1];
    if (pend[1]) begin
      r1_we = cur[1].we; r1_addr = cur[1].addr; r1_wdata = cur[1].wdata;
    end else begin
      r1_we = 1'($urandom); r1_addr = $urandom; r1_wdata = $urandom;
    end
  endtask

  // One clock cycle: check outputs of this cycle, update requesters, then
  // predict what the DUT does at the edge ending this cycle.
  task automatic step(input bit do_rst);
    bit in_acc, in_done, w;
    @(negedge clk);
    cyc++;
    in_acc  = m_active && (cyc >= m_t + 1) && (cyc <= m_t + LAT);
    in_done = m_active && (cyc == m_t + LAT + 1);
    if (in_done && !m_we) m_rdata = rom(m_addr);
    if (m_active && cyc >= m_t + LAT + 2) m_active = 1'b0;

    check_val("busy",   32'(busy),   32'(in_acc | in_done));
    check_val("mem_en", 32'(mem_en), 32'(in_acc));
    check_val("mem_we", 32'(mem_we), 32'(in_acc & m_we));
    check_val("r0_ack", 32'(r0_ack), 32'(in_done & ~m_owner));
    check_val("r1_ack", 32'(r1_ack), 32'(in_done & m_owner));
    check_val("rdata",  rdata, m_rdata);
    if (in_acc | in_done) check_val("owner", 32'(owner), 32'(m_owner));
    if (in_acc) check_val("mem_addr", mem_addr, m_addr);
    if (in_acc && m_we) check_val("mem_wdata", mem_wdata, m_wdata);

    if (r0_ack) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
    if (r1_ack) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end

    ack_now[0] = in_done && !m_owner;
    ack_now[1] = in_done && m_owner;
    advance(0);
    advance(1);
    drive_ports();
    reset = do_rst;
    // Memory data is only valid in the final access cycle.
    mem_rdata = (m_active && cyc == m_t + LAT) ? rom(m_addr) : (32'hBAD0_0000 ^ 32'(cyc));

    if (do_rst) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_rdata  = '0;
    end else if (!m_active && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 1'b1;
`else
        w = ~m_last;
`endif
      end else begin
        w = pend[1];
      end
      m_active = 1'b1;
      m_t      = cyc;
      m_owner  = w;
      m_last   = w;
      m_we     = cur[w].we;
      m_addr   = cur[w].addr;
      m_wdata  = cur[w].wdata;
    end
  endtask

  function automatic txn_t mk(input int g, input bit we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.gap = g; t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic lat_check(input string tag, input int t0);
    check_val({tag, "_ack_count"}, 32'(ack_cyc.size()), 32'd1);
    if (ack_cyc.size() > 0) check_val({tag, "_latency"}, 32'(ack_cyc[0] - t0), 32'(LAT + 1));
  endtask

  int t0;
  int exp_seq[6];
  int first_exp;

  initial begin
    reset = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    gap[0] = 0; gap[1] = 0;
    mem_rdata = '0;
    drive_ports();
`ifdef MEM_ARB_FIXED_PRIO_EN
    first_exp = 1;
    exp_seq = '{1, 1, 1, 0, 0, 0};
`else
    first_exp = 0;
    exp_seq = '{0, 1, 0, 1, 0, 1};
`endif

    step(1'b1);
    step(1'b1);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_owner", 32'(owner), 32'h0);

    // single read
    rq0.push_back(mk(0, 1'b0, 32'h10, 32'h0));
    ack_cyc.delete();
    step(1'b0);
    t0 = cyc;
    repeat (LAT + 3) step(1'b0);
    lat_check("read", t0);
    check_val("read_rdata", rdata, 32'hDEADBEEF);

    // single write
    rq1.push_back(mk(0, 1'b1, 32'h20, 32'h12345678));
    ack_cyc.delete();
    step(1'b0);
    t0 = cyc;
    repeat (LAT + 3) step(1'b0);
    lat_check("write", t0);
    check_val("write_rdata_kept", rdata, 32'hDEADBEEF);

    // contention right after reset
    step(1'b1);
    rq0.push_back(mk(0, 1'b0, 32'h40, 32'h0));
    rq1.push_back(mk(0, 1'b1, 32'h44, 32'hCAFE0001));
    ack_log.delete();
    repeat (2 * (LAT + 2) + 3) step(1'b0);
    check_val("contend_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check_val("contend_first", 32'(ack_log[0]), 32'(first_exp));
      check_val("contend_second", 32'(ack_log[1]), 32'(1 - first_exp));
    end

    // back-to-back, both held continuously
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(mk(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0));
      rq1.push_back(mk(0, 1'b1, 32'h200 + 32'(i * 4), 32'hA000 + 32'(i)));
    end
    ack_log.delete();
    ack_cyc.delete();
    repeat (6 * (LAT + 2) + 3) step(1'b0);
    check_val("b2b_count", 32'(ack_log.size()), 32'd6);
    if (ack_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check_val($sformatf("b2b_owner%0d", i), 32'(ack_log[i]), 32'(exp_seq[i]));
        if (i > 0) check_val($sformatf("b2b_spacing%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(LAT + 2));
      end
    end

    // reset in the first access cycle
    step(1'b1);
    rq0.push_back(mk(0, 1'b0, 32'h10, 32'h0));
    step(1'b0);
    step(1'b1);
    ack_cyc.delete();
    step(1'b0);
    check_val("rstmid_mem_en", 32'(mem_en), 32'h0);
    check_val("rstmid_busy", 32'(busy), 32'h0);
    check_val("rstmid_no_ack", 32'(r0_ack | r1_ack), 32'h0);
    t0 = cyc;
    repeat (LAT + 2) step(1'b0);
    lat_check("rstmid_retry", t0);
    check_val("rstmid_rdata", rdata, 32'hDEADBEEF);

    // read of 0x4
    rq0.push_back(mk(0, 1'b0, 32'h4, 32'h0));
    ack_cyc.delete();
    step(1'b0);
    t0 = cyc;
    repeat (LAT + 3) step(1'b0);
    lat_check("read4", t0);
    check_val("read4_rdata", rdata, 32'h55);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (rq0.size() == 0 && $urandom_range(0, 2) == 0)
        rq0.push_back(mk(int'($urandom_range(0, 4)), 1'($urandom), ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom, $urandom));
      if (rq1.size() == 0 && $urandom_range(0, 2) == 0)
        rq1.push_back(mk(int'($urandom_range(0, 4)), 1'($urandom), $urandom, $urandom));
      step($urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
